seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode/cathode 7-segment display; next generation of the single-digit hex-to-7-segment decoder.
- Holds an N-nibble display value and scans one digit at a time at a programmable rate.
- Decodes each nibble with the team's standard hex glyph table; applies per-digit blanking and leading-zero suppression.
- Applies new values only at frame boundaries, so a displayed number never tears.
- Sits between the calculator result/ALU path and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (≥2).
- SCAN_DIV, 1000, clock cycles each digit stays lit (≥2).
- SEG_ACTIVE_LOW, 0, 1 = invert seg_out and an_out at the pins.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle request to accept value_in
- value_in  in  4*NUM_DIGITS  digit i = bits [4i+3:4i]; digit 0 is the least significant
- blank_in  in  NUM_DIGITS  per-digit force-blank; sampled with load
- lzs_en  in  1  leading-zero suppression enable; sampled live
- seg_out  out  7  segments, bit0=a … bit6=g
- an_out  out  NUM_DIGITS  one-hot digit enable, bit i = digit i
- frame_tick  out  1  one-cycle pulse when digit index wraps to 0
- update_done  out  1  one-cycle pulse when a loaded value becomes active

Behaviour:
- Reset (async, rst=1):
  - div_cnt=0, dig_idx=0.
  - Active value, shadow value and blank registers = 0; pending=0.
  - seg_out=0, an_out=0, frame_tick=0, update_done=0. Values are pre-polarity; with SEG_ACTIVE_LOW the pins are all 1.
- Divider: div_cnt counts 0..SCAN_DIV-1. Terminal count (tc) sets div_cnt to 0 and advances dig_idx modulo NUM_DIGITS.
- Frame wrap: a cycle with tc and dig_idx==NUM_DIGITS-1. frame_tick is registered and asserts the cycle after the wrap cycle.
- Load:
  - load=1 captures value_in/blank_in into the shadow registers and sets pending.
  - A second load before the wrap overwrites the shadow; the last load wins, with no error.
- Apply:
  - On a wrap cycle with pending=1, shadow copies to active and pending clears.
  - update_done pulses on the same cycle as frame_tick.
- Simultaneous load and wrap: value_in bypasses the shadow, goes directly to active at that wrap, and pending clears.
- Output pipeline: seg_out/an_out are registered from the current dig_idx and active data, so there is 1-cycle latency from a dig_idx change.
  - an_out = one-hot(dig_idx) every cycle after the first post-reset clock.
- Decode: hex 0–F, segment order a..g in bits 0..6:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Blanking: seg_out=0 for the selected digit when any of these holds:
  - its blank bit is set;
  - lzs_en=1 and i>0 and all nibbles i..NUM_DIGITS-1 are 0.
  - Digit 0 is never suppressed by lzs_en.
  - an_out still asserts for a blanked digit, keeping constant duty.
- Polarity: SEG_ACTIVE_LOW inverts both output buses after the registers. frame_tick and update_done are always active-high.
- Reset mid-frame: everything returns to reset state immediately, and any pending load is discarded.

Optional Feature:
- Macro SEG7_SCAN_DP_EN.
- Defined:
  - Adds input dp_in[NUM_DIGITS-1:0], captured and shadowed/applied exactly like blank_in.
  - Adds output dp_out (1 bit), registered alongside seg_out, = active dp bit of the selected digit.
  - dp_out is inverted with SEG_ACTIVE_LOW and forced off when that digit is blanked.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_W=7 and NIBBLE_W=4;
  - the 16-entry glyph constant array;
  - function hex_to_seg(nibble) returning 7 bits.
- One natural sub-module is seg7_scan_timer: the divider plus digit index, producing tc, dig_idx and wrap.
- Decode, blanking and registers stay in the top level.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=0):
- Reset: assert rst mid-count → seg_out=0, an_out=0, flags 0 in the same cycle. Release → an_out=0001 one cycle after the first clock, then 0010 four cycles later.
- Load 0x1A3F, no blanks, lzs_en=0 → after the next frame_tick, the scan shows seg 71,4F,77,06 on an 0001,0010,0100,1000. update_done coincides with frame_tick.
- Leading zeros: load 0x0007 with lzs_en=1 → digits 3..1 seg=00, digit 0 seg=07. Same value with lzs_en=0 → digits 3..1 seg=3F.
- Tearing/last-wins: load 0x1111 then 0x2222 mid-frame → the display stays at the old value until the wrap, then 0x2222 only. Exactly one update_done pulse.
- Simultaneous load on the wrap cycle with 0x00FF → it becomes active at that wrap, with update_done on the next cycle and pending=0 afterward.
- SEG7_SCAN_DP_EN: dp_in=0100 → dp_out=1 only while an_out=0100. Setting blank_in=0100 → dp_out=0 there.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bus widths and the standard hex glyph table
// (segment a..g in bits 0..6, active-high, before any pin polarity).
package seg7_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    // Entries listed from F down to 0 so GLYPH_TABLE[n] is the glyph of n.
    localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timebase: divides clk by SCAN_DIV and steps the lit-digit index,
// flagging the terminal count (tc) and the frame wrap (tc on the last digit).
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tc,
    output logic             wrap,
    output logic [IDX_W-1:0] dig_idx
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] div_cnt;

    assign tc   = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap = tc && (dig_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (tc) begin
            div_cnt <= '0;
            dig_idx <= wrap ? '0 : dig_idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned value updates,
// per-digit blanking and leading-zero suppression. Optional decimal point: SEG7_SCAN_DP_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]        blank_in,
`ifdef SEG7_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]        dp_in,
    output logic                         dp_out,
`endif
    input  logic                         lzs_en,
    output logic [SEG_W-1:0]             seg_out,
    output logic [NUM_DIGITS-1:0]        an_out,
    output logic                         frame_tick,
    output logic                         update_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

    logic             tc;
    logic             wrap;
    logic [IDX_W-1:0] dig_idx;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tc      (tc),
        .wrap    (wrap),
        .dig_idx (dig_idx)
    );

    // load is a single-cycle strobe with no back-pressure: every asserted cycle
    // is accepted, the newest value replaces any not-yet-applied one, and it
    // reaches the display only at the next frame wrap (bypassing the shadow
    // when load and wrap coincide).
    logic [VAL_W-1:0]      shadow_val;
    logic [VAL_W-1:0]      active_val;
    logic [NUM_DIGITS-1:0] shadow_blank;
    logic [NUM_DIGITS-1:0] active_blank;
    logic                  pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val   <= '0;
            shadow_blank <= '0;
            active_val   <= '0;
            active_blank <= '0;
            pending      <= 1'b0;
        end else begin
            if (load) begin
                shadow_val   <= value_in;
                shadow_blank <= blank_in;
            end
            if (wrap && load) begin
                active_val   <= value_in;
                active_blank <= blank_in;
                pending      <= 1'b0;
            end else if (wrap && pending) begin
                active_val   <= shadow_val;
                active_blank <= shadow_blank;
                pending      <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick  <= 1'b0;
            update_done <= 1'b0;
        end else begin
            frame_tick  <= wrap;
            update_done <= wrap && (load || pending);
        end
    end

`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] active_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_dp <= '0;
            active_dp <= '0;
        end else begin
            if (load) begin
                shadow_dp <= dp_in;
            end
            if (wrap && load) begin
                active_dp <= dp_in;
            end else if (wrap && pending) begin
                active_dp <= shadow_dp;
            end
        end
    end
`endif

    // Selected digit and its blanking; zero_run walks down from the top digit
    // so at digit i it means "nibbles i..NUM_DIGITS-1 are all zero".
    logic [NIBBLE_W-1:0]   sel_nib;
    logic                  sel_blank;
    logic                  sel_lz;
    logic                  sel_dp;
    logic                  zero_run;
    logic                  digit_off;
    logic [SEG_W-1:0]      seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b0;
        sel_lz    = 1'b0;
        sel_dp    = 1'b0;
        zero_run  = 1'b1;
        an_next   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active_val[i*NIBBLE_W +: NIBBLE_W] == '0);
            an_next[i] = (dig_idx == IDX_W'(i));
            if (dig_idx == IDX_W'(i)) begin
                sel_nib   = active_val[i*NIBBLE_W +: NIBBLE_W];
                sel_blank = active_blank[i];
                sel_lz    = (i > 0) && zero_run;
`ifdef SEG7_SCAN_DP_EN
                sel_dp    = active_dp[i];
`endif
            end
        end
        digit_off = sel_blank || (lzs_en && sel_lz);
        seg_next  = digit_off ? '0 : hex_to_seg(sel_nib);
    end

    logic [SEG_W-1:0]      seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  dp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
            an_q  <= '0;
            dp_q  <= 1'b0;
        end else begin
            seg_q <= seg_next;
            an_q  <= an_next;
            dp_q  <= sel_dp && !digit_off;
        end
    end

    // Pin polarity is applied after the registers; the flags stay active-high.
    assign seg_out = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an_out  = (SEG_ACTIVE_LOW != 0) ? ~an_q  : an_q;
`ifdef SEG7_SCAN_DP_EN
    assign dp_out  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
`endif

    a_wrap_is_tc: assert property (@(posedge clk) disable iff (rst) wrap |-> tc);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4 cycles per digit, active-high pins).
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lzs_en = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_tick;
    logic        update_done;
`ifdef SEG7_SCAN_DP_EN
    logic [3:0]  dp_in = '0;
    logic        dp_out;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value_in    (value_in),
        .blank_in    (blank_in),
`ifdef SEG7_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .lzs_en      (lzs_en),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_tick  (frame_tick),
        .update_done (update_done)
    );

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      blank;
        logic            lzs;
        logic [3:0][6:0] seg;   // expected glyph per digit, index = digit
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b);
        value_in = v;
        blank_in = b;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_update(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (update_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({name, " update_done timeout"}, 32'(got), 32'd1);
        else      check({name, " frame_tick with update_done"}, 32'(frame_tick), 32'd1);
    endtask

    task automatic wait_frame(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (frame_tick) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({name, " frame_tick timeout"}, 32'(got), 32'd1);
    endtask

    // Advance until digit d is lit; returns its segments.
    task automatic show_digit(input int d, input string name, output logic [6:0] seg);
        logic [3:0] mask;
        mask = 4'(1 << d);
        for (int k = 0; k < 40; k++) begin
            if (an_out == mask) break;
            step();
        end
        if (an_out != mask) check({name, " digit select timeout"}, 32'(an_out), 32'(mask));
        seg = seg_out;
    endtask

    task automatic count_updates(input int cycles, output int cnt, output bit saw_glyph1);
        cnt = 0;
        saw_glyph1 = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (update_done) cnt++;
            if (seg_out == 7'h06) saw_glyph1 = 1'b1;
        end
    endtask

    initial begin
        logic [6:0] s;
        int cnt;
        bit saw1;
        logic [3:0][6:0] exp4;

        // segments listed {digit3, digit2, digit1, digit0}
        vec[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'h06, 7'h77, 7'h4F, 7'h71}};
        vec[1] = '{16'h0007, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}};
        vec[2] = '{16'h0007, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h07}};
        vec[3] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vec[4] = '{16'h1A3F, 4'b0010, 1'b0, {7'h06, 7'h77, 7'h00, 7'h71}};
        vec[5] = '{16'h0805, 4'b0000, 1'b1, {7'h00, 7'h7F, 7'h3F, 7'h6D}};
        vec[6] = '{16'hBCDE, 4'b1001, 1'b0, {7'h00, 7'h39, 7'h5E, 7'h00}};
        vec[7] = '{16'h9624, 4'b0000, 1'b1, {7'h6F, 7'h7D, 7'h5B, 7'h66}};

        // reset state and scan start
        step(); step(); step();
        check("rst seg", 32'(seg_out), 32'h0);
        check("rst an", 32'(an_out), 32'h0);
        check("rst frame_tick", 32'(frame_tick), 32'h0);
        check("rst update_done", 32'(update_done), 32'h0);
        rst = 1'b0;
        step();
        check("post-rst an first clock", 32'(an_out), 32'h1);
        step(); step(); step();
        check("post-rst an hold", 32'(an_out), 32'h1);
        step();
        check("post-rst an digit1", 32'(an_out), 32'h2);
        cnt = 5;
        for (int k = 0; k < 40; k++) begin
            if (frame_tick) break;
            step();
            cnt++;
        end
        check("first frame_tick edge count", 32'(cnt), 32'd16);

        // reset mid-frame discards a pending load
        do_load(16'h1234, 4'b0000);
        step(); step();
        rst = 1'b1;
        #1;
        check("async rst seg", 32'(seg_out), 32'h0);
        check("async rst an", 32'(an_out), 32'h0);
        check("async rst flags", 32'({frame_tick, update_done}), 32'h0);
        step(); step();
        rst = 1'b0;
        count_updates(40, cnt, saw1);
        check("pending dropped by rst", 32'(cnt), 32'd0);
        show_digit(0, "rst active", s);
        check("rst active digit0", 32'(s), 32'h3F);

        // table-driven vectors
        for (int v = 0; v < 8; v++) begin
            lzs_en = vec[v].lzs;
            do_load(vec[v].value, vec[v].blank);
            wait_update($sformatf("vec%0d", v));
            for (int d = 0; d < 4; d++) begin
                show_digit(d, $sformatf("vec%0d", v), s);
                check($sformatf("vec%0d digit%0d seg", v, d), 32'(s), 32'(vec[v].seg[d]));
            end
        end

        // tearing / last load wins; active is 0x9624 here
        lzs_en = 1'b0;
        wait_frame("tear");
        do_load(16'h1111, 4'b0000);
        step(); step();
        do_load(16'h2222, 4'b0000);
        show_digit(2, "tear old", s);
        check("tear old digit2 kept", 32'(s), 32'h7D);
        count_updates(40, cnt, saw1);
        check("tear update_done count", 32'(cnt), 32'd1);
        check("tear 0x1111 never shown", 32'(saw1), 32'd0);
        for (int d = 0; d < 4; d++) begin
            show_digit(d, "tear new", s);
            check($sformatf("tear new digit%0d", d), 32'(s), 32'h5B);
        end

        // load on the wrap cycle bypasses the shadow
        wait_frame("simul");
        for (int k = 0; k < 15; k++) step();
        value_in = 16'h00FF;
        blank_in = 4'b0000;
        load = 1'b1;
        step();
        load = 1'b0;
        check("simul frame_tick", 32'(frame_tick), 32'd1);
        check("simul update_done", 32'(update_done), 32'd1);
        exp4 = {7'h3F, 7'h3F, 7'h71, 7'h71};
        for (int d = 0; d < 4; d++) begin
            show_digit(d, "simul", s);
            check($sformatf("simul digit%0d", d), 32'(s), 32'(exp4[d]));
        end
        count_updates(40, cnt, saw1);
        check("simul pending cleared", 32'(cnt), 32'd0);

`ifdef SEG7_SCAN_DP_EN
        dp_in = 4'b0100;
        do_load(16'h1A3F, 4'b0000);
        wait_update("dp");
        for (int d = 0; d < 4; d++) begin
            show_digit(d, "dp", s);
            check($sformatf("dp digit%0d", d), 32'(dp_out), (d == 2) ? 32'd1 : 32'd0);
        end
        do_load(16'h1A3F, 4'b0100);
        wait_update("dp blank");
        show_digit(2, "dp blank", s);
        check("dp blanked digit2 dp", 32'(dp_out), 32'd0);
        check("dp blanked digit2 seg", 32'(s), 32'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
